// File: rtl/effects_pipeline_mc.sv
// effects_pipeline_mc
//   Multi-channel gain/clip effects pipeline. Offset-binary ADC samples tagged
//   with a channel index are converted to signed Q1.(fxp_size-1), scaled by a
//   per-channel unsigned gain, saturated, then passed through a selectable
//   clipping mode. Fixed 4-cycle latency; valid and channel tags travel with
//   the data. No backpressure: one sample per cycle.
//
//   Optional build macro: EFFECTS_PEAK_HOLD_EN enables the peak-magnitude hold
//   register on o_peak. Without it o_peak is 0 and i_peak_clr is ignored.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_par_gain        packed gains, channel k at [k*gain_size +: gain_size]
//   i_par_mode        0 bypass, 1 hard clip, 2 soft clip, 3 mute
//   i_par_threshold   clip threshold magnitude T
//   valid             input sample strobe
//   i_channel         channel tag of i_sample
//   i_sample          offset-binary sample
//   o_valid           output strobe
//   o_channel         channel tag aligned with o_sample
//   o_sample          processed signed sample
//   o_clip            saturation or clipping changed the sample
//   o_peak            held peak magnitude
//   i_peak_clr        clears the peak register
module effects_pipeline_mc #(
  parameter int unsigned bits_per_level     = 12,
  parameter int unsigned bits_per_gain_frac = 4,
  parameter int unsigned gain_size          = 11,
  parameter int unsigned fxp_size           = 16,
  parameter int unsigned num_channels       = 2,
  localparam int unsigned ch_w = (num_channels > 1) ? $clog2(num_channels) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [num_channels*gain_size-1:0] i_par_gain,
  input  logic [1:0]                        i_par_mode,
  input  logic [fxp_size-2:0]               i_par_threshold,
  input  logic                              valid,
  input  logic [ch_w-1:0]                   i_channel,
  input  logic [bits_per_level-1:0]         i_sample,
  output logic                              o_valid,
  output logic [ch_w-1:0]                   o_channel,
  output logic [fxp_size-1:0]               o_sample,
  output logic                              o_clip,
  output logic [fxp_size-2:0]               o_peak,
  input  logic                              i_peak_clr
);

  localparam int unsigned prod_w = fxp_size + gain_size + 1;

  localparam logic [1:0] mode_bypass = 2'd0;
  localparam logic [1:0] mode_hard   = 2'd1;
  localparam logic [1:0] mode_soft   = 2'd2;
  localparam logic [1:0] mode_mute   = 2'd3;

  // S0 capture
  logic                      v0;
  logic [bits_per_level-1:0] sample0;
  logic [ch_w-1:0]           ch0;
  logic [1:0]                mode0;
  logic [fxp_size-2:0]       thr0;
  logic [gain_size-1:0]      gain0;
  logic [gain_size-1:0]      gain_sel;

  // S1 convert
  logic                       v1;
  logic signed [fxp_size-1:0] x1;
  logic [ch_w-1:0]            ch1;
  logic [1:0]                 mode1;
  logic [fxp_size-2:0]        thr1;
  logic [gain_size-1:0]       gain1;
  logic signed [fxp_size-1:0] conv;

  // S2 gain + saturate
  logic                       v2;
  logic signed [fxp_size-1:0] x2;
  logic                       sat2;
  logic [ch_w-1:0]            ch2;
  logic [1:0]                 mode2;
  logic [fxp_size-2:0]        thr2;
  logic signed [prod_w-1:0]   prod;
  logic signed [prod_w-1:0]   shifted;
  logic signed [fxp_size-1:0] gained;
  logic                       pos_ovf;
  logic                       neg_ovf;

  // S3 mode
  logic                       v3;
  logic [fxp_size-1:0]        y3;
  logic                       clip3;
  logic [ch_w-1:0]            ch3;
  logic signed [fxp_size:0]   xe;
  logic [fxp_size:0]          mag_x;
  logic [fxp_size:0]          thr_e;
  logic [fxp_size:0]          mag_y;
  logic [fxp_size:0]          y_wide;
  logic [fxp_size-1:0]        y_comb;
  logic                       clip_comb;

  // Out-of-range channel index leaves gain at zero.
  always_comb begin
    gain_sel = '0;
    for (int unsigned k = 0; k < num_channels; k++) begin
      if (i_channel == ch_w'(k))
        gain_sel = i_par_gain[k*gain_size +: gain_size];
    end
  end

  always_comb begin
    conv = '0;
    conv[fxp_size-1 -: bits_per_level] =
      {~sample0[bits_per_level-1], sample0[bits_per_level-2:0]};
  end

  always_comb begin
    prod    = x1 * $signed({1'b0, gain1});
    shifted = prod >>> bits_per_gain_frac;
    // Fits in fxp_size only if all bits above the result sign match it.
    pos_ovf = !shifted[prod_w-1] &&  (|shifted[prod_w-2:fxp_size-1]);
    neg_ovf =  shifted[prod_w-1] && !(&shifted[prod_w-2:fxp_size-1]);
    if (pos_ovf)
      gained = {1'b0, {(fxp_size-1){1'b1}}};
    else if (neg_ovf)
      gained = {1'b1, {(fxp_size-1){1'b0}}};
    else
      gained = shifted[fxp_size-1:0];
  end

  // Magnitudes are one bit wider than the sample so the most-negative value
  // has a representable absolute value.
  always_comb begin
    xe     = {x2[fxp_size-1], x2};
    mag_x  = xe[fxp_size] ? unsigned'(-xe) : unsigned'(xe);
    thr_e  = {2'b00, thr2};
    mag_y  = mag_x;
    case (mode2)
      mode_hard: if (mag_x > thr_e) mag_y = thr_e;
      mode_soft: if (mag_x > thr_e) mag_y = thr_e + ((mag_x - thr_e) >> 1);
      default:   mag_y = mag_x;
    endcase
    y_wide = xe[fxp_size] ? (~mag_y + 1'b1) : mag_y;
    if (mode2 == mode_bypass) begin
      y_comb    = x2;
      clip_comb = sat2;
    end else if (mode2 == mode_mute) begin
      y_comb    = '0;
      clip_comb = 1'b0;
    end else begin
      y_comb    = y_wide[fxp_size-1:0];
      clip_comb = sat2 || (y_comb != x2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0; sample0 <= '0; ch0 <= '0; mode0 <= '0; thr0 <= '0; gain0 <= '0;
      v1 <= 1'b0; x1 <= '0; ch1 <= '0; mode1 <= '0; thr1 <= '0; gain1 <= '0;
      v2 <= 1'b0; x2 <= '0; sat2 <= 1'b0; ch2 <= '0; mode2 <= '0; thr2 <= '0;
      v3 <= 1'b0; y3 <= '0; clip3 <= 1'b0; ch3 <= '0;
      o_valid <= 1'b0; o_sample <= '0; o_clip <= 1'b0; o_channel <= '0;
    end else begin
      v0 <= valid;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
      o_valid <= v3;
      if (valid) begin
        sample0 <= i_sample;
        ch0     <= i_channel;
        mode0   <= i_par_mode;
        thr0    <= i_par_threshold;
        gain0   <= gain_sel;
      end
      if (v0) begin
        x1 <= conv; ch1 <= ch0; mode1 <= mode0; thr1 <= thr0; gain1 <= gain0;
      end
      if (v1) begin
        x2 <= gained; sat2 <= pos_ovf || neg_ovf;
        ch2 <= ch1; mode2 <= mode1; thr2 <= thr1;
      end
      if (v2) begin
        y3 <= y_comb; clip3 <= clip_comb; ch3 <= ch2;
      end
      // Output register supplies the fourth cycle of latency.
      if (v3) begin
        o_sample <= y3; o_clip <= clip3; o_channel <= ch3;
      end
    end
  end

`ifdef EFFECTS_PEAK_HOLD_EN
  logic [fxp_size-1:0] out_mag;
  logic [fxp_size-2:0] out_mag_sat;

  always_comb begin
    out_mag     = o_sample[fxp_size-1] ? (~o_sample + 1'b1) : o_sample;
    out_mag_sat = out_mag[fxp_size-1] ? '1 : out_mag[fxp_size-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_peak <= '0;
    else if (i_peak_clr)
      o_peak <= '0;
    else if (o_valid && (out_mag_sat > o_peak))
      o_peak <= out_mag_sat;
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = i_peak_clr;
  assign o_peak = '0;
`endif

endmodule

// File: tb/tb_effects_pipeline_mc.sv
module tb_effects_pipeline_mc;

  localparam int NCH = 2;
  localparam int GW  = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NCH*GW-1:0] i_par_gain = '0;
  logic [1:0]       i_par_mode = '0;
  logic [14:0]      i_par_threshold = '0;
  logic             valid = 1'b0;
  logic [0:0]       i_channel = '0;
  logic [11:0]      i_sample = '0;
  logic             o_valid;
  logic [0:0]       o_channel;
  logic [15:0]      o_sample;
  logic             o_clip;
  logic [14:0]      o_peak;
  logic             i_peak_clr = 1'b0;

  effects_pipeline_mc dut (
    .clk(clk), .rst(rst), .i_par_gain(i_par_gain), .i_par_mode(i_par_mode),
    .i_par_threshold(i_par_threshold), .valid(valid), .i_channel(i_channel),
    .i_sample(i_sample), .o_valid(o_valid), .o_channel(o_channel),
    .o_sample(o_sample), .o_clip(o_clip), .o_peak(o_peak), .i_peak_clr(i_peak_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int ch;
    int y;
    bit clip;
  } exp_t;

  exp_t sbq[$];
  int   gains[NCH];
  int   mode_v = 0;
  int   thr_v  = 0;
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: real-valued rules with integer arithmetic.
  function automatic void model(input int s, input int ch, output int y, output bit clip);
    int x, g, a, mag, sgn;
    longint p, q;
    bit sat;
    x = (s - 2048) * 16;
    g = (ch < NCH) ? gains[ch] : 0;
    p = longint'(x) * g;
    q = (p < 0) ? -((-p + 15) / 16) : p / 16;
    sat = 0;
    if (q > 32767) begin q = 32767; sat = 1; end
    if (q < -32768) begin q = -32768; sat = 1; end
    x = int'(q);
    sgn = (x < 0) ? -1 : 1;
    a = (x < 0) ? -x : x;
    mag = a;
    case (mode_v)
      1: if (a > thr_v) mag = thr_v;
      2: if (a > thr_v) mag = thr_v + (a - thr_v) / 2;
      default: mag = a;
    endcase
    y = (mode_v == 3) ? 0 : sgn * mag;
    clip = (mode_v == 3) ? 1'b0 : (sat || (y != x));
    y = y & 32'hFFFF;
  endfunction

  task automatic apply_params();
    for (int k = 0; k < NCH; k++) i_par_gain[k*GW +: GW] = GW'(gains[k]);
    i_par_mode = 2'(mode_v);
    i_par_threshold = 15'(thr_v);
  endtask

  // One cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic issue(input bit v, input int s, input int ch);
    int y;
    bit c;
    apply_params();
    valid = v;
    i_sample = 12'(s);
    i_channel = 1'(ch);
    if (v) begin
      model(s, ch, y, c);
      sbq.push_back('{cyc + 5, ch, y, c});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  logic [15:0] last_sample = '0;
  logic [0:0]  last_ch = '0;
  logic        last_clip = 1'b0;
  int          model_peak = 0;
  bit          running = 0;

  always @(negedge clk) begin
    exp_t e;
    int a;
    if (rst) begin
      last_sample = '0; last_ch = '0; last_clip = 1'b0; model_peak = 0;
    end else if (running) begin
      chk("o_peak", int'(o_peak), model_peak);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk("o_valid", int'(o_valid), 1);
        chk("o_sample", int'(o_sample), e.y);
        chk("o_channel", int'(o_channel), e.ch);
        chk("o_clip", int'(o_clip), int'(e.clip));
      end else begin
        chk("o_valid_idle", int'(o_valid), 0);
        chk("hold_sample", int'(o_sample), int'(last_sample));
        chk("hold_channel", int'(o_channel), int'(last_ch));
        chk("hold_clip", int'(o_clip), int'(last_clip));
      end
`ifdef EFFECTS_PEAK_HOLD_EN
      a = $signed(o_sample);
      if (a < 0) a = -a;
      if (a > 32767) a = 32767;
      if (i_peak_clr) model_peak = 0;
      else if (o_valid && a > model_peak) model_peak = a;
`else
      a = 0;
`endif
      last_sample = o_sample; last_ch = o_channel; last_clip = o_clip;
    end
  end

  initial begin
    gains[0] = 16; gains[1] = 32;
    apply_params();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_sample", int'(o_sample), 0);
    chk("rst_o_channel", int'(o_channel), 0);
    chk("rst_o_clip", int'(o_clip), 0);
    chk("rst_o_peak", int'(o_peak), 0);
    rst = 1'b0;
    running = 1;
    issue(0, 0, 0);

    // Basic conversion, gain 1.0 and 2.0, alternating channels
    mode_v = 0;
    issue(1, 'hC00, 0);
    issue(1, 'h400, 0);
    issue(1, 'hC00, 1);
    for (int i = 0; i < 8; i++) issue(1, 'h800 + i * 37, i % 2);
    repeat (6) issue(0, 0, 0);

    // Modes with T = 0x2000
    gains[0] = 16; thr_v = 'h2000;
    mode_v = 1; issue(1, 'hC00, 0);
    mode_v = 2; issue(1, 'hC00, 0);
    mode_v = 2; issue(1, 'h400, 0);
    mode_v = 3; issue(1, 'hC00, 0);
    // Boundaries: T=0 hard clip, most-negative input, saturation at max gain
    thr_v = 0; mode_v = 1;
    issue(1, 'hC00, 0);
    issue(1, 'h800, 0);
    issue(1, 'h000, 0);
    mode_v = 2; issue(1, 'h000, 0);
    thr_v = 'h7FFF; issue(1, 'h000, 1);
    gains[1] = 2047; mode_v = 0;
    issue(1, 'h000, 1);
    issue(1, 'hFFF, 1);
    issue(1, 'h801, 1);
    gains[1] = 0; issue(1, 'hFFF, 1);
    gains[1] = 32;
    repeat (6) issue(0, 0, 0);

    // Valid gap with a mode change during the gap
    thr_v = 'h1000; mode_v = 0;
    for (int i = 0; i < 3; i++) issue(1, 'hB00 + i * 16, i % 2);
    mode_v = 1;
    repeat (5) issue(0, 0, 0);
    for (int i = 0; i < 3; i++) issue(1, 'hB00 + i * 16, i % 2);
    repeat (6) issue(0, 0, 0);

    // Peak hold: outputs 0x1000, 0xC000, 0x2000 then clear
    gains[0] = 16; mode_v = 0;
    issue(1, 'h900, 0);
    issue(1, 'h400, 0);
    issue(1, 'hA00, 0);
    repeat (6) issue(0, 0, 0);
`ifdef EFFECTS_PEAK_HOLD_EN
    chk("peak_after_three", int'(o_peak), 'h4000);
`else
    chk("peak_disabled", int'(o_peak), 0);
`endif
    i_peak_clr = 1'b1;
    issue(0, 0, 0);
    i_peak_clr = 1'b0;
    issue(0, 0, 0);
    chk("peak_cleared", int'(o_peak), 0);

    // Randomized traffic with parameter changes and peak clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        mode_v = $urandom_range(0, 3);
        thr_v = $urandom_range(0, 32767);
        for (int k = 0; k < NCH; k++) gains[k] = $urandom_range(0, 2047);
      end
      i_peak_clr = ($urandom_range(0, 19) == 0);
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 4095), $urandom_range(0, NCH - 1));
    end
    i_peak_clr = 1'b0;
    repeat (6) issue(0, 0, 0);

    // Reset with samples in flight: outputs clear asynchronously
    gains[0] = 16; gains[1] = 32; mode_v = 0;
    issue(1, 'hC00, 1);
    issue(1, 'hC00, 0);
    issue(1, 'hC00, 1);
    valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_o_valid", int'(o_valid), 0);
    chk("async_rst_o_sample", int'(o_sample), 0);
    chk("async_rst_o_channel", int'(o_channel), 0);
    chk("async_rst_o_clip", int'(o_clip), 0);
    chk("async_rst_o_peak", int'(o_peak), 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) issue(0, 0, 0);
    issue(1, 'h400, 1);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sbq.size() > 0; i++) issue(0, 0, 0);
    if (sbq.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", sbq.size());
    end
    running = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/effects_pipeline_mc.md
Name: effects_pipeline_mc

Overview:
Multi-channel, mode-selectable successor to the single-channel gain effects pipeline. It takes time-multiplexed offset-binary ADC samples tagged with a channel index and converts each to signed fixed point. It applies a per-channel gain, saturates, then applies a selectable clipping mode. It sits between the ADC deserialiser and the DAC/output mixer, with a fixed 4-cycle latency and valid and channel tags carried alongside the data.

Parameters:
bits_per_level, 12, ADC sample width (offset binary)
bits_per_gain_frac, 4, fractional bits of each gain word
gain_size, 11, width of one gain word (unsigned)
fxp_size, 16, output width, signed Q1.(fxp_size-1); must be >= bits_per_level
num_channels, 2, channel count (>=1); ch_w = max(1, $clog2(num_channels))

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
i_par_gain  in  num_channels*gain_size  packed gains; channel k at bits [k*gain_size +: gain_size]
i_par_mode  in  2  0 bypass, 1 hard clip, 2 soft clip, 3 mute
i_par_threshold  in  fxp_size-1  clip threshold magnitude T (unsigned)
valid  in  1  input sample strobe
i_channel  in  ch_w  channel tag of i_sample
i_sample  in  bits_per_level  offset-binary sample
o_valid  out  1  output strobe
o_channel  out  ch_w  channel tag aligned with o_sample
o_sample  out  fxp_size  processed signed sample
o_clip  out  1  high with o_valid when saturation or clipping changed the sample
o_peak  out  fxp_size-1  peak magnitude (see Optional Feature)
i_peak_clr  in  1  clears peak register

Behaviour:
- Reset: all pipeline registers cleared; o_valid=0, o_channel=0, o_sample=0, o_clip=0, o_peak=0. Reset mid-stream discards in-flight samples; no o_valid for them.
- Pipeline has no backpressure; one sample per cycle accepted.
- Latency: sample accepted at edge N appears with o_valid=1 after edge N+4.
- Valid tag shifts every cycle. Data/channel/clip stage registers load only when their stage valid is 1, so o_sample/o_channel/o_clip hold their last values while o_valid=0.
- S0 (capture):
  - Register sample, channel, mode and threshold.
  - Select the gain word by i_channel; an out-of-range index selects gain 0.
  - Parameters are captured per sample, so a parameter change affects only samples accepted on or after the change edge.
- S1 (convert):
  - Invert the sample MSB (offset binary to two's complement).
  - Left-align to fxp_size by appending (fxp_size - bits_per_level) zero LSBs.
- S2 (gain + saturate):
  - Signed x times unsigned gain gives a product of width fxp_size+gain_size+1.
  - Arithmetic shift right by bits_per_gain_frac, truncating toward -inf.
  - Saturate to [-2^(fxp_size-1), 2^(fxp_size-1)-1]; set sat flag if limited.
- S3 (mode):
  - Bypass: y = x.
  - Hard clip: y = clamp(x, -T, T).
  - Soft clip: if |x| > T then y = sign(x)*(T + ((|x|-T)>>1)), else y = x.
  - Mute: y = 0, o_clip=0, o_valid still asserted.
  - o_clip = sat OR (y != x), except in mute.
- T=0 in hard clip gives all outputs 0 with o_clip=1 for nonzero x. Most-negative x uses |x| computed in fxp_size+1 bits (no overflow).

Optional Feature:
- Macro: EFFECTS_PEAK_HOLD_EN.
- Defined: on each o_valid, o_peak <= max(o_peak, |o_sample| saturated to fxp_size-1 bits). i_peak_clr forces o_peak to 0; if both occur in the same cycle, clear wins and the current sample is not counted.
- Undefined: o_peak is constant 0 and i_peak_clr is ignored. Port list is unchanged.

Test Plan:
- Defaults, ch0 gain 16 (1.0), mode 0, i_sample 0xC00 -> 4 cycles later o_valid=1, o_sample=0x4000, o_channel=0, o_clip=0; i_sample 0x400 -> 0xC000.
- ch1 gain 32 (2.0), mode 0, i_sample 0xC00, i_channel=1 -> o_sample=0x7FFF, o_clip=1, o_channel=1; back-to-back alternating ch0/ch1 streams keep tags aligned every cycle.
- Gain 1.0, T=0x2000: mode 1 with 0xC00 -> 0x2000, o_clip=1; mode 2 -> 0x3000, o_clip=1; mode 2 with 0x400 -> 0xD000; mode 3 -> 0x0000, o_clip=0.
- Valid gap: 3 samples, 5 idle cycles, change i_par_mode during the gap -> earlier samples use the old mode and later ones the new; o_sample holds during idle cycles.
- Assert rst with 3 samples in flight -> outputs 0 immediately (asynchronously); no o_valid for flushed samples.
- With EFFECTS_PEAK_HOLD_EN: outputs 0x1000, 0xC000, 0x2000 -> o_peak=0x4000; pulse i_peak_clr -> 0; without the macro o_peak stays 0.
